ex_stage_unit: RTL
==================

Name: ex_stage_unit

Overview:
- Execute stage that consumes the ID/EX barrier outputs (operands plus memory and register-write control) and registers its result and the control bits into the EX/MEM boundary.
- Single-cycle ALU/multiply path, plus an iterative 32-step divider that stalls upstream while busy.
- Owns the EX/MEM pipeline register, so downstream sees registered outputs only.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_STEPS, 32, restoring-divider iterations; must equal XLEN.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge
- rst_n  input  1  synchronous active-low reset
- exValid  input  1  ID/EX slot holds a real instruction (0 = bubble)
- exAluOp  input  4  operation select; encodings in ex_stage_pkg
- exLHSRegisterValue  input  32  operand A
- exRHSRegisterValue  input  32  operand B and store data
- exIsMemoryWrite  input  1  store control, passed through
- exShouldUseMemoryData  input  1  load/writeback-select control, passed through
- exIsRegisterWrite  input  1  register-file write control, passed through
- exFlush  input  1  kill the instruction in EX (branch redirect)
- exStall  output  1  hold IF/ID and ID/EX barriers; combinational
- memValid  output  1  EX/MEM slot valid
- memAluResult  output  32  registered result
- memStoreData  output  32  registered copy of operand B
- memIsMemoryWrite  output  1  registered control
- memShouldUseMemoryData  output  1  registered control
- memIsRegisterWrite  output  1  registered control

Behaviour:
- Reset (rst_n=0 at an edge): all mem* outputs go to 0, the divider FSM goes to IDLE, and the divider counter and registers clear. Reset overrides flush and stall.
- Operations:
  - ADD, SUB, AND, OR, XOR.
  - SLL, SRL, SRA use shift amount B[4:0].
  - SLT (signed compare) and SLTU (unsigned compare) return 0 or 1.
  - MUL returns the low 32 bits of A*B. MULH returns the high 32 bits of the signed×signed product.
  - DIV, DIVU, REM, REMU.
  - Unused encodings return 0.
- Non-divide ops: when exValid=1, the result and control bits are captured at the next edge (1-cycle latency). exStall stays 0.
- Divider FSM:
  - States are IDLE, BUSY, DONE.
  - exStall = exValid & isDiv & (state != DONE) & ~exFlush.
  - IDLE with a valid divide op:
    - On divide-by-zero or signed overflow, go to DONE.
    - Otherwise latch |A|, |B| and the result-sign flags, set counter=0 and go to BUSY.
  - BUSY: perform one restoring step per cycle. When counter reaches DIV_STEPS-1, go to DONE.
  - DONE: exStall=0, the EX/MEM register captures the result, and the FSM returns to IDLE.
  - Normal divide latency: op presented in cycle 0, exStall high for cycles 0..32, result visible in memAluResult after the edge ending cycle 33.
- Divide special cases (RISC-V semantics):
  - Divide by zero: quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned ops.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Result appears after 2 edges.
  - Signed results: quotient is negated when the operand signs differ. Remainder takes the sign of A.
- While exStall=1, the EX/MEM register loads a bubble: memValid=0 and all three control outputs 0. Data outputs are don't-care but held.
- exFlush=1:
  - The EX/MEM register loads a bubble.
  - The divider aborts to IDLE from any state, with no result written.
  - exStall is 0 in that cycle.
- exValid=0: the EX/MEM register loads a bubble and an IDLE FSM stays IDLE.
- exValid dropping during BUSY without a flush is illegal. Verification must flag it with an assertion.
- Control outputs are forced to 0 whenever memValid=0.

Decomposition:
- ex_stage_pkg holds:
  - the 4-bit aluOp encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULH=11, DIV=12, DIVU=13, REM=14, REMU=15;
  - the divider state enum;
  - XLEN.
- iterative_divider is a sub-module holding the FSM, counter, restoring datapath and the special-case bypass. It has a start/abort/done interface plus quotient and remainder outputs.
- The ALU/multiply logic and the EX/MEM register stay in ex_stage_unit.

Test Plan:
- ADD with A=0x7FFFFFFF, B=1, exIsRegisterWrite=1 -> after 1 edge: memAluResult=0x80000000, memIsRegisterWrite=1, memValid=1, exStall never high.
- DIV with A=-100 (0xFFFFFF9C), B=7 -> exStall high 33 cycles, then memAluResult=0xFFFFFFF2 (-14). Repeat as REM -> 0xFFFFFFFE (-2).
- DIVU with B=0, A=0x1234 -> memAluResult=0xFFFFFFFF after 2 edges. REMU with the same operands -> 0x00001234.
- DIV with A=0x80000000, B=0xFFFFFFFF -> memAluResult=0x80000000. MULH with A=B=0x80000000 -> 0x40000000.
- Start DIVU, assert exFlush at BUSY cycle 10 -> exStall drops the same cycle, memValid=0, FSM IDLE. A following ADD completes in 1 cycle.
- Drive rst_n=0 for one edge in BUSY cycle 5 -> all mem* outputs 0, exStall=0 after release. A divide reissued afterwards produces the correct result.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage.
package ex_stage_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_MULH = 4'd11,
    ALU_DIV  = 4'd12,
    ALU_DIVU = 4'd13,
    ALU_REM  = 4'd14,
    ALU_REMU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // DIV/DIVU/REM/REMU occupy encodings 12..15.
  function automatic logic is_div_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/ex_stage_unit_divider.sv
// Iterative restoring divider: one quotient bit per cycle, with a bypass for
// divide-by-zero and signed overflow that skips the iteration entirely.
module iterative_divider
  import ex_stage_pkg::*;
#(
  parameter int W     = 32,
  parameter int STEPS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CW = $clog2(STEPS);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_q, rem_d;     // one spare bit so the shifted partial remainder never overflows
  logic [W-1:0]  quo_q, quo_d;     // dividend shifts out the top while quotient bits shift in
  logic [W-1:0]  dvs_q, dvs_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;

  logic          a_neg, b_neg, div0, ovf, ge;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh;

  assign a_neg  = signed_i & a_i[W-1];
  assign b_neg  = signed_i & b_i[W-1];
  assign a_mag  = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag  = b_neg ? (~b_i + 1'b1) : b_i;
  assign div0   = (b_i == '0);
  assign ovf    = signed_i & (a_i == {1'b1, {(W-1){1'b0}}}) & (&b_i);
  assign rem_sh = {rem_q[W-1:0], quo_q[W-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          negq_d = 1'b0;
          negr_d = 1'b0;
          if (div0) begin
            quo_d   = '1;
            rem_d   = {1'b0, a_i};
            state_d = DONE;
          end else if (ovf) begin
            quo_d   = a_i;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_d = {quo_q[W-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  // Divider state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign done_o      = (state_q == DONE);
  assign quotient_o  = negq_q ? (~quo_q + 1'b1) : quo_q;
  assign remainder_o = negr_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU/multiply, iterative divider, and the EX/MEM
// pipeline register. Only XLEN = DIV_STEPS = 32 is supported.
module ex_stage_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exValid,
  input  logic [3:0]      exAluOp,
  input  logic [XLEN-1:0] exLHSRegisterValue,
  input  logic [XLEN-1:0] exRHSRegisterValue,
  input  logic            exIsMemoryWrite,
  input  logic            exShouldUseMemoryData,
  input  logic            exIsRegisterWrite,
  input  logic            exFlush,
  output logic            exStall,
  output logic            memValid,
  output logic [XLEN-1:0] memAluResult,
  output logic [XLEN-1:0] memStoreData,
  output logic            memIsMemoryWrite,
  output logic            memShouldUseMemoryData,
  output logic            memIsRegisterWrite
);

  import ex_stage_pkg::*;

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0]   a, b, alu_res, div_q, div_r, res;
  logic [SW-1:0]     shamt;
  logic [2*XLEN-1:0] prod;
  logic              is_div, div_done, div_start, capture;

  logic              valid_q, mw_q, um_q, rw_q;
  logic [XLEN-1:0]   res_q, sd_q;

  assign a      = exLHSRegisterValue;
  assign b      = exRHSRegisterValue;
  assign shamt  = b[SW-1:0];
  // Sign-extending both operands to 2*XLEN makes the low 2*XLEN product bits
  // the signed x signed product; its low half is also the plain MUL result.
  assign prod   = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign is_div = is_div_op(exAluOp);

  // The divider only acts on start while IDLE, so holding start high through
  // BUSY/DONE is harmless.
  assign div_start = exValid & is_div & ~exFlush;
  assign exStall   = exValid & is_div & ~div_done & ~exFlush;
  assign capture   = exValid & ~exStall & ~exFlush;

  iterative_divider #(.W(XLEN), .STEPS(DIV_STEPS)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .abort_i     (exFlush),
    .signed_i    (~exAluOp[0]),
    .a_i         (a),
    .b_i         (b),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  // Single-cycle ALU and multiply result select.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(exAluOp))
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $signed(a) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_MUL:  alu_res = prod[XLEN-1:0];
      ALU_MULH: alu_res = prod[2*XLEN-1:XLEN];
      default:  alu_res = '0;
    endcase
  end

  // REM/REMU have aluOp[1] set; DIV/DIVU clear.
  assign res = is_div ? (exAluOp[1] ? div_r : div_q) : alu_res;

  // EX/MEM register: bubble on stall/flush/invalid, data held across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      sd_q    <= '0;
      mw_q    <= 1'b0;
      um_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      res_q   <= res;
      sd_q    <= b;
      mw_q    <= exIsMemoryWrite;
      um_q    <= exShouldUseMemoryData;
      rw_q    <= exIsRegisterWrite;
    end else begin
      valid_q <= 1'b0;
      mw_q    <= 1'b0;
      um_q    <= 1'b0;
      rw_q    <= 1'b0;
    end
  end

  assign memValid               = valid_q;
  assign memAluResult           = res_q;
  assign memStoreData           = sd_q;
  assign memIsMemoryWrite       = mw_q;
  assign memShouldUseMemoryData = um_q;
  assign memIsRegisterWrite     = rw_q;

endmodule
